// File: rtl/hqc_rmencod_dupl_if.sv
// hqc_rmencod_dupl_if
//   Handshake bundle for the RM(1,7) duplicating encoder.
//   slave  : encoder side (consumes start/bytes, produces codeword copies)
//   master : surrounding logic / RS encoder side and downstream assembler
//   Signals:
//     start_i, start_ready_o              frame start handshake
//     din_i[7:0], din_valid_i, din_ready_o message byte stream
//     dout_o[127:0], dout_valid_o, dout_ready_i,
//     dout_start_o, dout_last_o           codeword copy stream with framing
interface hqc_rmencod_dupl_if;
   logic         start_i;
   logic         start_ready_o;
   logic [7:0]   din_i;
   logic         din_valid_i;
   logic         din_ready_o;
   logic [127:0] dout_o;
   logic         dout_valid_o;
   logic         dout_ready_i;
   logic         dout_start_o;
   logic         dout_last_o;

   modport slave (
      input  start_i, din_i, din_valid_i, dout_ready_i,
      output start_ready_o, din_ready_o, dout_o, dout_valid_o, dout_start_o, dout_last_o
   );

   modport master (
      output start_i, din_i, din_valid_i, dout_ready_i,
      input  start_ready_o, din_ready_o, dout_o, dout_valid_o, dout_start_o, dout_last_o
   );
endinterface

// File: rtl/hqc_rmencod_dupl.sv
// hqc_rmencod_dupl
//   Reed-Muller RM(1,7) encoder with repetition for the HQC encapsulation
//   path. Each accepted message byte is expanded to a 128-bit first-order RM
//   codeword, emitted MULTIPLICITY times; a frame is N1 bytes.
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   synchronous reset, active-high
//     bus     hqc_rmencod_dupl_if.slave (start, byte input, codeword output)
//   Optional build macro HQC_RMENCOD_PREFETCH_EN: one-entry byte prefetch
//   while emitting, removing the per-codeword LOAD bubble.
module hqc_rmencod_dupl #(
   parameter int PARAM_SECURITY = 128,
   parameter int MULTIPLICITY   = (PARAM_SECURITY == 128) ? 3 : 5,
   parameter int N1             = (PARAM_SECURITY == 128) ? 46 :
                                  (PARAM_SECURITY == 192) ? 56 : 90
) (
   input logic               clk_i,
   input logic               rst_i,
   hqc_rmencod_dupl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

   localparam logic [6:0] LAST_BYTE = 7'(N1 - 1);
   localparam logic [2:0] LAST_COPY = 3'(MULTIPLICITY - 1);

   state_t       state, state_nxt;
   logic [6:0]   byte_cnt;
   logic [2:0]   copy_cnt;
   logic [127:0] cw;

   logic start_rdy, din_rdy, dout_vld, dout_sop, dout_eop;
   logic din_hs, dout_hs, last_copy, last_byte;

   // Bit j of the codeword is msg[7] xor the parity of msg[6:0] & j.
   function automatic logic [127:0] rm_encode(input logic [7:0] msg);
      logic [127:0] cw_v;
      logic [6:0]   j7;
      cw_v = '0;
      for (int unsigned j = 0; j < 128; j++) begin
         j7      = 7'(j);
         cw_v[j] = msg[7] ^ (^(msg[6:0] & j7));
      end
      return cw_v;
   endfunction

`ifdef HQC_RMENCOD_PREFETCH_EN
   logic         pf_valid;
   logic [127:0] pf_cw;
   assign din_rdy = (state == LOAD) |
                    ((state == EMIT) & ~pf_valid & ((8'(byte_cnt) + 8'd1) < 8'(N1)));
`else
   assign din_rdy = (state == LOAD);
`endif

   assign din_hs    = bus.din_valid_i & din_rdy;
   assign dout_hs   = (state == EMIT) & bus.dout_ready_i;
   assign last_copy = (copy_cnt == LAST_COPY);
   assign last_byte = (byte_cnt == LAST_BYTE);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_rdy = 1'b0;
      dout_vld  = 1'b0;
      dout_sop  = 1'b0;
      dout_eop  = 1'b0;
      case (state)
         IDLE: begin
            start_rdy = 1'b1;
            if (bus.start_i) state_nxt = LOAD;
         end
         LOAD: begin
            if (din_hs) state_nxt = EMIT;
         end
         EMIT: begin
            dout_vld = 1'b1;
            dout_sop = (copy_cnt == '0);
            dout_eop = last_copy & last_byte;
            if (dout_hs && last_copy) begin
               if (last_byte) state_nxt = IDLE;
`ifdef HQC_RMENCOD_PREFETCH_EN
               else if (pf_valid || din_hs) state_nxt = EMIT;
`endif
               else state_nxt = LOAD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byte_cnt <= '0;
         copy_cnt <= '0;
         cw       <= '0;
`ifdef HQC_RMENCOD_PREFETCH_EN
         pf_valid <= 1'b0;
         pf_cw    <= '0;
`endif
      end else begin
         if (state == IDLE && bus.start_i) begin
            byte_cnt <= '0;
            copy_cnt <= '0;
`ifdef HQC_RMENCOD_PREFETCH_EN
            pf_valid <= 1'b0;
`endif
         end
         if (state == LOAD && din_hs) begin
            cw       <= rm_encode(bus.din_i);
            copy_cnt <= '0;
         end
         if (dout_hs) begin
            if (last_copy) begin
               byte_cnt <= byte_cnt + 7'd1;
               copy_cnt <= '0;
`ifdef HQC_RMENCOD_PREFETCH_EN
               // A byte arriving on the same edge as the last copy goes
               // straight to the output register rather than the prefetch slot.
               if (!last_byte) begin
                  if (pf_valid) begin
                     cw       <= pf_cw;
                     pf_valid <= 1'b0;
                  end else if (din_hs) begin
                     cw <= rm_encode(bus.din_i);
                  end
               end
`endif
            end else begin
               copy_cnt <= copy_cnt + 3'd1;
            end
         end
`ifdef HQC_RMENCOD_PREFETCH_EN
         if (state == EMIT && din_hs && !(dout_hs && last_copy)) begin
            pf_cw    <= rm_encode(bus.din_i);
            pf_valid <= 1'b1;
         end
`endif
      end
   end

   assign bus.start_ready_o = start_rdy;
   assign bus.din_ready_o   = din_rdy;
   assign bus.dout_o        = cw;
   assign bus.dout_valid_o  = dout_vld;
   assign bus.dout_start_o  = dout_sop;
   assign bus.dout_last_o   = dout_eop;

endmodule

// File: tb/tb_hqc_rmencod_dupl.sv
module tb_hqc_rmencod_dupl;
   localparam int M_T    = 3;
   localparam int N1_T   = 46;
   localparam int TOTAL  = N1_T * M_T;
   localparam int BUDGET = 5000;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   hqc_rmencod_dupl_if bus();

   hqc_rmencod_dupl #(
      .PARAM_SECURITY(128),
      .MULTIPLICITY  (M_T),
      .N1            (N1_T)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]   frame_bytes [N1_T];
   logic [127:0] got_word    [TOTAL];

   // Reference: first-order RM codeword as a Walsh row, complemented when msg[7]=1.
   function automatic logic [127:0] model_cw(input logic [7:0] b);
      logic [127:0] w;
      logic [6:0]   jj;
      for (int j = 0; j < 128; j++) begin
         jj   = 7'(j);
         w[j] = b[7] ^ (($countones(b[6:0] & jj) % 2) == 1);
      end
      return w;
   endfunction

   task automatic idle_inputs();
      bus.start_i      = 1'b0;
      bus.din_i        = '0;
      bus.din_valid_i  = 1'b0;
      bus.dout_ready_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if (bus.start_ready_o !== 1'b1 || bus.din_ready_o !== 1'b0 ||
          bus.dout_valid_o !== 1'b0 || bus.dout_start_o !== 1'b0 ||
          bus.dout_last_o !== 1'b0 || bus.dout_o !== 128'h0) begin
         n_err++;
         $display("FAIL %s: got sr=%b dr=%b v=%b s=%b l=%b d=%h, exp sr=1 dr=0 v=0 s=0 l=0 d=0",
                  tag, bus.start_ready_o, bus.din_ready_o, bus.dout_valid_o,
                  bus.dout_start_o, bus.dout_last_o, bus.dout_o);
      end
   endtask

   // Runs one frame from start to the last output handshake (or abort).
   task automatic do_frame(input int rdy_pct, input int vld_pct, input int abort_word,
                           input bit extra_start, output int frame_cycles, output int valid_span);
      int words, bidx, cyc, first_valid, last_cyc;
      bit prev_stall, sr_bad, dr_bad, aborted;
      logic [127:0] prev_dout, exp_w;
      logic prev_s, prev_l, exp_s, exp_l;
      words = 0; bidx = 0; cyc = 0; first_valid = -1; last_cyc = 0;
      prev_stall = 0; sr_bad = 0; dr_bad = 0; aborted = 0;
      prev_dout = '0; prev_s = 0; prev_l = 0;

      @(negedge clk_i);
      n_cmp++;
      if (bus.start_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL start_ready_before_start: got %b exp 1", bus.start_ready_o);
      end
      bus.start_i = 1'b1;
      @(negedge clk_i);
      bus.start_i = 1'b0;

      while (words < TOTAL && cyc < BUDGET) begin
         cyc++;
         if (bus.start_ready_o !== 1'b0) sr_bad = 1;
`ifndef HQC_RMENCOD_PREFETCH_EN
         if (bus.dout_valid_o === 1'b1 && bus.din_ready_o === 1'b1) dr_bad = 1;
`endif
         if (bus.dout_valid_o === 1'b1 && first_valid < 0) first_valid = cyc;

         if (prev_stall) begin
            n_cmp++;
            if (bus.dout_valid_o !== 1'b1 || bus.dout_o !== prev_dout ||
                bus.dout_start_o !== prev_s || bus.dout_last_o !== prev_l) begin
               n_err++;
               $display("FAIL stall_hold word%0d: got v=%b s=%b l=%b d=%h exp v=1 s=%b l=%b d=%h",
                        words, bus.dout_valid_o, bus.dout_start_o, bus.dout_last_o,
                        bus.dout_o, prev_s, prev_l, prev_dout);
            end
         end

         if (abort_word >= 0 && words == abort_word && bus.dout_valid_o === 1'b1) begin
            aborted = 1;
            break;
         end

         bus.din_valid_i  = (bidx < N1_T) && ($urandom_range(99) < vld_pct);
         bus.din_i        = (bidx < N1_T) ? frame_bytes[bidx] : 8'($urandom);
         bus.dout_ready_i = ($urandom_range(99) < rdy_pct);
         bus.start_i      = extra_start ? 1'($urandom) : 1'b0;
         if (bus.din_valid_i && bus.din_ready_o === 1'b1) bidx++;

         prev_stall = 0;
         if (bus.dout_valid_o === 1'b1) begin
            if (bus.dout_ready_i) begin
               exp_w = model_cw(frame_bytes[words / M_T]);
               exp_s = (words % M_T) == 0;
               exp_l = (words == TOTAL - 1);
               n_cmp++;
               if (bus.dout_o !== exp_w) begin
                  n_err++;
                  $display("FAIL word%0d dout: got %h exp %h", words, bus.dout_o, exp_w);
               end
               n_cmp++;
               if (bus.dout_start_o !== exp_s || bus.dout_last_o !== exp_l) begin
                  n_err++;
                  $display("FAIL word%0d flags: got start=%b last=%b exp start=%b last=%b",
                           words, bus.dout_start_o, bus.dout_last_o, exp_s, exp_l);
               end
               got_word[words] = bus.dout_o;
               words++;
               last_cyc = cyc;
            end else begin
               prev_stall = 1;
               prev_dout  = bus.dout_o;
               prev_s     = bus.dout_start_o;
               prev_l     = bus.dout_last_o;
            end
         end
         @(negedge clk_i);
      end

      frame_cycles = cyc;
      valid_span   = (first_valid < 0) ? 0 : last_cyc - first_valid + 1;

      if (aborted) begin
         rst_i = 1'b1;
         idle_inputs();
         bus.start_i = 1'b1;
         @(negedge clk_i);
         check_reset_outputs("mid_frame_reset");
         rst_i = 1'b0;
         bus.start_i = 1'b0;
         for (int k = 0; k < 6; k++) begin
            bus.dout_ready_i = 1'b1;
            @(negedge clk_i);
         end
         n_cmp++;
         if (bus.dout_valid_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL after_abort_quiet: got v=%b sr=%b exp v=0 sr=1",
                     bus.dout_valid_o, bus.start_ready_o);
         end
         idle_inputs();
      end else begin
         idle_inputs();
         n_cmp++;
         if (words != TOTAL) begin
            n_err++;
            $display("FAIL frame_timeout: got %0d words exp %0d", words, TOTAL);
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
         end
         n_cmp++;
         if (bus.start_ready_o !== 1'b1 || bus.dout_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL end_of_frame_idle: got sr=%b v=%b exp sr=1 v=0",
                     bus.start_ready_o, bus.dout_valid_o);
         end
         n_cmp++;
         if (sr_bad) begin
            n_err++;
            $display("FAIL start_ready_in_frame: got 1 exp 0");
         end
`ifndef HQC_RMENCOD_PREFETCH_EN
         n_cmp++;
         if (dr_bad) begin
            n_err++;
            $display("FAIL din_ready_in_emit: got 1 exp 0");
         end
`endif
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N1_T; i++) frame_bytes[i] = 8'($urandom);
   endtask

   task automatic test_reset();
      int fc, vs;
      idle_inputs();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check_reset_outputs("reset_state");
      // start together with reset: reset must win
      bus.start_i = 1'b1;
      @(negedge clk_i);
      check_reset_outputs("reset_beats_start");
      bus.start_i = 1'b0;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_reset_outputs("idle_after_reset");
      fc = 0; vs = 0;
   endtask

   task automatic test_known_vectors();
      int fc, vs;
      logic [127:0] exp_c [5];
      fill_random();
      frame_bytes[0] = 8'h00;
      frame_bytes[1] = 8'h80;
      frame_bytes[2] = 8'h01;
      frame_bytes[3] = 8'h40;
      frame_bytes[4] = 8'hC1;
      exp_c[0] = 128'h0;
      exp_c[1] = {128{1'b1}};
      exp_c[2] = {8{16'hAAAA}};
      exp_c[3] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      exp_c[4] = {8{16'h5555}} ^ {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      do_frame(100, 100, -1, 1'b0, fc, vs);
      for (int c = 0; c < 5; c++) begin
         for (int k = 0; k < M_T; k++) begin
            n_cmp++;
            if (got_word[c * M_T + k] !== exp_c[c]) begin
               n_err++;
               $display("FAIL known_cw%0d copy%0d: got %h exp %h",
                        c, k, got_word[c * M_T + k], exp_c[c]);
            end
         end
      end
   endtask

   task automatic test_random_backpressure();
      int fc, vs;
      fill_random();
      do_frame(50, 70, -1, 1'b1, fc, vs);
   endtask

   task automatic test_reset_mid_frame();
      int fc, vs;
      fill_random();
      do_frame(100, 100, 10 * M_T + 1, 1'b0, fc, vs);
      fill_random();
      do_frame(60, 100, -1, 1'b0, fc, vs);
   endtask

   task automatic test_back_to_back();
      int fc, vs;
      fill_random();
      do_frame(100, 100, -1, 1'b0, fc, vs);
      n_cmp++;
`ifdef HQC_RMENCOD_PREFETCH_EN
      if (vs != TOTAL) begin
         n_err++;
         $display("FAIL throughput_span: got %0d cycles exp %0d", vs, TOTAL);
      end
`else
      if (fc < N1_T * (M_T + 1)) begin
         n_err++;
         $display("FAIL throughput_min: got %0d cycles exp >= %0d", fc, N1_T * (M_T + 1));
      end
`endif
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_random_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end
endmodule
